// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_seq_pkg;

    // Opcode map (same 16-op set as the original combinational ALU)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL1 = 4'h4;
    localparam logic [3:0] OP_SHR1 = 4'h5;
    localparam logic [3:0] OP_ROL1 = 4'h6;
    localparam logic [3:0] OP_ROR1 = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside the packed flag register
    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int FLAG_D    = 4;
    localparam int NUM_FLAGS = 5;

    typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the issue stage, the ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry_out;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             dz;

    // Issuer / consumer side
    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, carry_out, zero, neg, ovf, dz
    );

    // ALU side
    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, carry_out, zero, neg, ovf, dz
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiplier and restoring divider, one bit per cycle.
// Multiplier lives in lo_q and the product accumulates in hi_q:lo_q; for division
// lo_q holds the dividend shifting into the quotient and hi_q the partial remainder.
// done flags the final iteration; result presents the value that iteration produces.
module alu_seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_is_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH:0]   step_hi_s;
    logic [WIDTH-1:0] step_lo_s;

    // One multiply or divide step computed from the current registers
    always_comb begin
        mul_sum_s   = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opd_q});
        if (div_q) begin
            step_hi_s = div_ge_s ? (div_shift_s - {1'b0, opd_q}) : div_shift_s;
            step_lo_s = {lo_q[WIDTH-2:0], div_ge_s};
        end else begin
            step_hi_s = {1'b0, mul_sum_s[WIDTH:1]};
            step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        end
    end

    // Next-state: load on start, iterate while busy, otherwise hold
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opd_d  = opd_q;
        cnt_d  = cnt_q;
        if (start) begin
            busy_d = 1'b1;
            div_d  = op_is_div;
            hi_d   = {(WIDTH+1){1'b0}};
            lo_d   = opa;
            opd_d  = opb;
            cnt_d  = {CNT_W{1'b0}};
        end else if (busy_q) begin
            hi_d   = step_hi_s;
            lo_d   = step_lo_s;
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = (cnt_q != LAST_CNT);
        end else begin
            busy_d = 1'b0;
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= {(WIDTH+1){1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            opd_q  <= {WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opd_q  <= opd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == LAST_CNT);
    assign result = div_q ? {{WIDTH{1'b0}}, step_lo_s} : {step_hi_s[WIDTH-1:0], step_lo_s};

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: valid/ready in, registered result + flags out.
// Single-cycle ops complete on the accept edge; MUL and DIV (b != 0) run in the
// iterative engine for WIDTH cycles. A finished result can retire on the same
// edge that accepts the next operation.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    import alu_seq_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t           flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             is_iter_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] sc_res_s;
    logic             sc_c_s;
    logic             sc_v_s;
    logic             sc_d_s;
    logic             md_start_s;
    logic             md_busy_s;
    logic             md_done_s;
    logic [2*WIDTH-1:0] md_result_s;

    // Pack result-derived and op-specific flags into one word
    function automatic flags_t make_flags(input logic [WIDTH-1:0] r, input logic c,
                                          input logic v, input logic d);
        flags_t f;
        f         = {NUM_FLAGS{1'b0}};
        f[FLAG_C] = c;
        f[FLAG_Z] = (r == {WIDTH{1'b0}});
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_V] = v;
        f[FLAG_D] = d;
        return f;
    endfunction

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start_s),
        .op_is_div (bus.alu_sel == OP_DIV),
        .opa       (bus.a),
        .opb       (bus.b),
        .busy      (md_busy_s),
        .done      (md_done_s),
        .result    (md_result_s)
    );

    // Single-cycle operation mux, evaluated on the presented operands
    always_comb begin
        sum_s    = {1'b0, bus.a} + {1'b0, bus.b};
        diff_s   = {1'b0, bus.a} - {1'b0, bus.b};
        sc_res_s = {WIDTH{1'b0}};
        sc_c_s   = 1'b0;
        sc_v_s   = 1'b0;
        sc_d_s   = 1'b0;
        case (bus.alu_sel)
            OP_ADD: begin
                sc_res_s = sum_s[WIDTH-1:0];
                sc_c_s   = sum_s[WIDTH];
                sc_v_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s = diff_s[WIDTH-1:0];
                sc_c_s   = diff_s[WIDTH];
                sc_v_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL:  sc_res_s = {WIDTH{1'b0}};
            OP_DIV: begin
                // Only divide-by-zero takes the single-cycle path
                sc_res_s = {WIDTH{1'b1}};
                sc_d_s   = 1'b1;
            end
            OP_SHL1: begin
                sc_res_s = {bus.a[WIDTH-2:0], 1'b0};
                sc_c_s   = bus.a[WIDTH-1];
            end
            OP_SHR1: begin
                sc_res_s = {1'b0, bus.a[WIDTH-1:1]};
                sc_c_s   = bus.a[0];
            end
            OP_ROL1: begin
                sc_res_s = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
                sc_c_s   = bus.a[WIDTH-1];
            end
            OP_ROR1: begin
                sc_res_s = {bus.a[0], bus.a[WIDTH-1:1]};
                sc_c_s   = bus.a[0];
            end
            OP_AND:  sc_res_s = bus.a & bus.b;
            OP_OR:   sc_res_s = bus.a | bus.b;
            OP_XOR:  sc_res_s = bus.a ^ bus.b;
            OP_NOR:  sc_res_s = ~(bus.a | bus.b);
            OP_NAND: sc_res_s = ~(bus.a & bus.b);
            OP_XNOR: sc_res_s = ~(bus.a ^ bus.b);
            OP_GT:   sc_res_s = (bus.a > bus.b)  ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            OP_EQ:   sc_res_s = (bus.a == bus.b) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Handshake FSM next-state, result capture and engine start
    always_comb begin
        in_ready_s  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
        accept_s    = bus.in_valid && in_ready_s;
        is_iter_s   = (bus.alu_sel == OP_MUL) ||
                      ((bus.alu_sel == OP_DIV) && (bus.b != {WIDTH{1'b0}}));
        state_d     = state_q;
        res_d       = res_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        md_start_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (is_iter_s) begin
                        state_d     = ST_BUSY;
                        md_start_s  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = ST_DONE;
                        res_d       = sc_res_s;
                        flags_d     = make_flags(sc_res_s, sc_c_s, sc_v_s, sc_d_s);
                        out_valid_d = 1'b1;
                    end
                end else if ((state_q == ST_DONE) && bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_BUSY: begin
                if (md_done_s) begin
                    state_d     = ST_DONE;
                    res_d       = md_result_s[WIDTH-1:0];
                    flags_d     = make_flags(md_result_s[WIDTH-1:0],
                                             |md_result_s[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
                    out_valid_d = 1'b1;
                end else if (!md_busy_s) begin
                    // Engine idle while we wait on it: recover rather than hang
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = ST_BUSY;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            res_q       <= {WIDTH{1'b0}};
            flags_q     <= {NUM_FLAGS{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = res_q;
    assign bus.carry_out = flags_q[FLAG_C];
    assign bus.zero      = flags_q[FLAG_Z];
    assign bus.neg       = flags_q[FLAG_N];
    assign bus.ovf       = flags_q[FLAG_V];
    assign bus.dz        = flags_q[FLAG_D];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): expectations are queued at issue time
// by an integer reference model and popped when a result handshake completes.
module tb_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [4:0]  flg;   // {carry, zero, neg, ovf, dz}
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input string tag, input logic [3:0] sel,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] y;
        logic        c, v, d;
        int          sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        y = 16'h0; c = 1'b0; v = 1'b0; d = 1'b0;
        case (sel)
            4'h0: begin s = 17'(a) + 17'(b); y = s[15:0]; c = s[16]; r = sa + sb; v = (r > 32767) || (r < -32768); end
            4'h1: begin y = a - b; c = (a < b); r = sa - sb; v = (r > 32767) || (r < -32768); end
            4'h2: begin p = 32'(a) * 32'(b); y = p[15:0]; c = (p[31:16] != 16'h0); end
            4'h3: begin if (b == 16'h0) begin y = 16'hFFFF; d = 1'b1; end else y = a / b; end
            4'h4: begin y = a << 1; c = a[15]; end
            4'h5: begin y = a >> 1; c = a[0]; end
            4'h6: begin y = {a[14:0], a[15]}; c = a[15]; end
            4'h7: begin y = {a[0], a[15:1]}; c = a[0]; end
            4'h8: y = a & b;
            4'h9: y = a | b;
            4'hA: y = a ^ b;
            4'hB: y = ~(a | b);
            4'hC: y = ~(a & b);
            4'hD: y = ~(a ^ b);
            4'hE: y = (a > b) ? 16'd1 : 16'd0;
            4'hF: y = (a == b) ? 16'd1 : 16'd0;
            default: y = 16'h0;
        endcase
        e.tag = tag;
        e.res = y;
        e.flg = {c, (y == 16'h0), y[15], v, d};
        return e;
    endfunction

    // Result monitor: a handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val({mon_e.tag, "_out"}, 32'(bus.alu_out), 32'(mon_e.res));
                check_val({mon_e.tag, "_flags"},
                          32'({bus.carry_out, bus.zero, bus.neg, bus.ovf, bus.dz}), 32'(mon_e.flg));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one op (called #1 after a rising edge); returns #1 after the accept edge
    task automatic issue(input string tag, input logic [3:0] sel,
                         input logic [15:0] a, input logic [15:0] b);
        int n;
        sb_q.push_back(model(tag, sel, a, b));
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.a        = a;
        bus.b        = b;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.alu_sel  = 4'($urandom);
    endtask

    // Count falling edges from accept until out_valid; in_ready must stay low meanwhile
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid && bus.in_ready) rdy_seen = 1'b1;
        end while (!bus.out_valid && n < 40);
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_busy_rdy"}, 32'(rdy_seen), 32'd0);
    endtask

    initial begin
        exp_t        stall_e;
        logic [3:0]  rsel;
        logic [15:0] ra, rb;
        int          n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        bus.alu_sel   = 4'h0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_alu_out",   32'(bus.alu_out), 32'd0);
        check_val("rst_flags", 32'({bus.carry_out, bus.zero, bus.neg, bus.ovf, bus.dz}), 32'd0);
        sync();
        rst_n = 1'b1;

        sync(); issue("add_wrap", 4'h0, 16'hFFFF, 16'h0001); wait_valid("add_wrap", 1);
        sync(); issue("sub_ovf",  4'h1, 16'h8000, 16'h0001); wait_valid("sub_ovf", 1);
        sync(); issue("sub_brw",  4'h1, 16'h0001, 16'h0002); wait_valid("sub_brw", 1);
        sync(); issue("mul_hi",   4'h2, 16'h0100, 16'h0100); wait_valid("mul_hi", W + 1);
        sync(); issue("div_100_7", 4'h3, 16'd100, 16'd7);   wait_valid("div_100_7", W + 1);
        sync(); issue("div_zero", 4'h3, 16'h1234, 16'h0000); wait_valid("div_zero", 1);

        // Hold the result in DONE for 5 cycles, then retire it while accepting ROL1
        sync();
        bus.out_ready = 1'b0;
        stall_e = model("xor_stall", 4'hA, 16'hA5A5, 16'h0FF0);
        issue("xor_stall", 4'hA, 16'hA5A5, 16'h0FF0);
        wait_valid("xor_stall", 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_valid", 32'(bus.out_valid), 32'd1);
            check_val("stall_out",   32'(bus.alu_out), 32'(stall_e.res));
            check_val("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        sync();
        bus.out_ready = 1'b1;
        issue("rol_b2b", 4'h6, 16'h8001, 16'h0000);
        wait_valid("rol_b2b", 1);

        // Abort a multiply with reset during its 8th iteration
        sync();
        issue("mul_abort", 4'h2, 16'h1234, 16'h5678);
        repeat (8) @(negedge clk);
        check_val("abort_busy_valid", 32'(bus.out_valid), 32'd0);
        check_val("abort_busy_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_val("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("abort_alu_out",   32'(bus.alu_out), 32'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 32'(bus.in_ready), 32'd1);
        check_val("post_rst_valid", 32'(bus.out_valid), 32'd0);
        sync(); issue("and_after", 4'h8, 16'hF0F0, 16'h0FF0); wait_valid("and_after", 1);

        // Back-to-back random traffic, including MUL/DIV and divide-by-zero
        sync();
        for (int i = 0; i < 24; i++) begin
            rsel = 4'($urandom);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            if (rsel == 4'h3 && $urandom_range(0, 3) == 0) rb = 16'h0;
            issue($sformatf("rnd%0d_op%0h", i, rsel), rsel, ra, rb);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
